// File: rtl/arty_clk_monitor.sv
// rtl/arty_clk_monitor.sv - frequency/lock checker for a generated clock against clk_in
`timescale 1ns/1ps
module arty_clk_monitor #(
  parameter int DIV_LOG2 = 2,
  parameter int WINDOW   = 1024,
  parameter int EXPECT   = 128,
  parameter int TOL      = 4,
  parameter int LOCK_CNT = 4,
  parameter int CW       = 16
) (
  input  logic          clk_in,
  input  logic          resetn,
  input  logic          mon_clk,
  input  logic          enable,
  output logic          locked_out,
  output logic          fault,
  output logic [CW-1:0] meas_count,
  output logic          meas_valid
);

  localparam int WW   = $clog2(WINDOW);
  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int LO_I = (EXPECT > TOL) ? (EXPECT - TOL) : 0;
  localparam logic [CW-1:0] MEAS_LO   = CW'(LO_I);
  localparam logic [CW-1:0] MEAS_HI   = CW'(EXPECT + TOL);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED, ST_FAULT} state_e;

  // ---------------- mon_clk domain: prescaler ----------------
  logic [1:0]          mrst_q, mrst_d;
  logic [DIV_LOG2-1:0] pre_q, pre_d;
  logic                mon_rstn;
  logic                mon_div;

  // Next-state for the mon_clk reset synchroniser and the free-running prescaler.
  always_comb begin
    mrst_d = {mrst_q[0], 1'b1};
    pre_d  = pre_q + DIV_LOG2'(1);
  end

  // Reset synchroniser for mon_clk: asserts immediately, releases on a mon_clk edge.
  always_ff @(posedge mon_clk or negedge resetn) begin
    if (!resetn) mrst_q <= 2'b00;
    else         mrst_q <= mrst_d;
  end

  assign mon_rstn = mrst_q[1];

  // Prescaler counter; its MSB is the divided clock sampled by clk_in.
  always_ff @(posedge mon_clk or negedge mon_rstn) begin
    if (!mon_rstn) pre_q <= '0;
    else           pre_q <= pre_d;
  end

  assign mon_div = pre_q[DIV_LOG2-1];

  // ---------------- clk_in domain: measurement and lock FSM ----------------
  logic [1:0]    crst_q, crst_d;
  logic          ref_rstn;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  state_e        state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [CW-1:0] edge_q, edge_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [CW-1:0] meas_q, meas_d;
  logic          valid_q, valid_d;
  logic          locked_q, locked_d;
  logic          fault_q, fault_d;
  logic          rise, close, good;
  logic [CW-1:0] edge_sum;

  // Next-state for the clk_in reset synchroniser.
  always_comb begin
    crst_d = {crst_q[0], 1'b1};
  end

  // Reset synchroniser for clk_in: asserts immediately, releases on a clk_in edge.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) crst_q <= 2'b00;
    else         crst_q <= crst_d;
  end

  assign ref_rstn = crst_q[1];

  // Edge detection, window counting, measurement close and lock/fault decisions.
  always_comb begin
    s1_d  = mon_div;
    s2_d  = s1_q;
    s3_d  = s2_q;
    rise  = s2_q & ~s3_q;
    close = (win_q == WIN_LAST);
    // A rise on the closing cycle still belongs to the closing window.
    edge_sum = (&edge_q) ? edge_q : (edge_q + CW'(rise));
    good     = (edge_sum >= MEAS_LO) && (edge_sum <= MEAS_HI);

    state_d    = state_q;
    win_d      = win_q;
    edge_d     = edge_q;
    good_cnt_d = good_cnt_q;
    meas_d     = meas_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    fault_d    = fault_q;

    if (!enable) begin
      // Dropping enable discards the open window and clears status; meas_count holds.
      state_d    = ST_IDLE;
      win_d      = '0;
      edge_d     = '0;
      good_cnt_d = '0;
      locked_d   = 1'b0;
      fault_d    = 1'b0;
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_ACQUIRE;
      win_d      = '0;
      edge_d     = '0;
      good_cnt_d = '0;
    end else begin
      win_d  = close ? '0 : (win_q + WW'(1));
      edge_d = close ? '0 : edge_sum;
      if (close) begin
        meas_d  = edge_sum;
        valid_d = 1'b1;
        case (state_q)
          ST_ACQUIRE: begin
            if (!good) begin
              good_cnt_d = '0;
            end else if (good_cnt_q == GOOD_LAST) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GW'(1);
            end
          end
          ST_LOCKED: begin
            if (!good) begin
              state_d  = ST_FAULT;
              locked_d = 1'b0;
              fault_d  = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // All clk_in-domain state registers.
  always_ff @(posedge clk_in or negedge ref_rstn) begin
    if (!ref_rstn) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= ST_IDLE;
      win_q      <= '0;
      edge_q     <= '0;
      good_cnt_q <= '0;
      meas_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      state_q    <= state_d;
      win_q      <= win_d;
      edge_q     <= edge_d;
      good_cnt_q <= good_cnt_d;
      meas_q     <= meas_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      fault_q    <= fault_d;
    end
  end

  assign locked_out = locked_q;
  assign fault      = fault_q;
  assign meas_count = meas_q;
  assign meas_valid = valid_q;

endmodule

// File: tb/tb_arty_clk_monitor.sv
// tb/tb_arty_clk_monitor.sv - self-checking bench for arty_clk_monitor
`timescale 1ns/1ps
module tb_arty_clk_monitor;

  localparam int WINDOW   = 1024;
  localparam int EXPECT   = 128;
  localparam int TOL      = 4;
  localparam int LOCK_CNT = 4;
  localparam int CW       = 16;

  logic          clk_in = 1'b0;
  logic          mon_clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          locked_out, fault, meas_valid;
  logic [CW-1:0] meas_count;

  real mon_half = 10.0;
  bit  mon_run  = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    real half;
    int  lo;
    int  hi;
    bit  good;
  } win_t;

  typedef struct {
    win_t w;
    int   nwin;
    bit   exp_lock;
  } vec_t;

  win_t plan[$];
  bit   hist[$];
  vec_t tbl[5];

  arty_clk_monitor #(
    .DIV_LOG2(2), .WINDOW(WINDOW), .EXPECT(EXPECT), .TOL(TOL),
    .LOCK_CNT(LOCK_CNT), .CW(CW)
  ) dut (
    .clk_in(clk_in), .resetn(resetn), .mon_clk(mon_clk), .enable(enable),
    .locked_out(locked_out), .fault(fault), .meas_count(meas_count),
    .meas_valid(meas_valid)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    forever begin
      #(mon_half);
      if (mon_run) mon_clk = ~mon_clk;
    end
  end

  task automatic chk(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Window whose ideal mon_div edge count over WINDOW*10ns is n+0.5, so it reads n or n+1.
  function automatic win_t mk(input int n);
    win_t w;
    w.half = 1280.0 / (real'(n) + 0.5);
    w.lo   = n;
    w.hi   = n + 1;
    w.good = (n >= EXPECT - TOL) && (n + 1 <= EXPECT + TOL);
    return w;
  endfunction

  // Lock is won by the first run of LOCK_CNT good windows; any bad window after that is a fault.
  function automatic void model(output bit lk, output bit ft);
    int  lock_at = -1;
    bit  bad_after = 1'b0;
    for (int i = LOCK_CNT - 1; i < hist.size() && lock_at < 0; i++) begin
      bit all_good = 1'b1;
      for (int j = i - LOCK_CNT + 1; j <= i; j++) all_good &= hist[j];
      if (all_good) lock_at = i;
    end
    if (lock_at >= 0)
      for (int i = lock_at + 1; i < hist.size(); i++) if (!hist[i]) bad_after = 1'b1;
    lk = (lock_at >= 0) && !bad_after;
    ft = (lock_at >= 0) && bad_after;
  endfunction

  task automatic run_plan(input bit fresh);
    int cnt;
    bit lk, ft;
    if (fresh) begin
      @(negedge clk_in);
      enable = 1'b0;
      hist.delete();
      mon_half = plan[0].half;
      repeat (20) @(negedge clk_in);
      chk("idle_locked", locked_out, 0, 0);
      chk("idle_fault", fault, 0, 0);
      enable = 1'b1;
    end
    for (int k = 0; k < plan.size(); k++) begin
      if (k > 0 || !fresh) mon_half = plan[k].half;
      cnt = 0;
      do begin
        @(negedge clk_in);
        cnt++;
      end while (!meas_valid && cnt < WINDOW + 20);
      chk("window_len", cnt, (k == 0 && fresh) ? WINDOW + 1 : WINDOW,
          (k == 0 && fresh) ? WINDOW + 1 : WINDOW);
      chk("meas_count", int'(meas_count), plan[k].lo, plan[k].hi);
      hist.push_back(plan[k].good);
      model(lk, ft);
      chk("locked_out", locked_out, int'(lk), int'(lk));
      chk("fault", fault, int'(ft), int'(ft));
    end
  endtask

  initial begin
    int cnt, nvalid, first_v, n;

    tbl[0] = '{w: '{half: 11.3636, lo: 112, hi: 113, good: 1'b0}, nwin: 5, exp_lock: 1'b0};
    tbl[1] = '{w: mk(134), nwin: 5, exp_lock: 1'b0};
    tbl[2] = '{w: mk(124), nwin: 5, exp_lock: 1'b1};
    tbl[3] = '{w: mk(131), nwin: 5, exp_lock: 1'b1};
    tbl[4] = '{w: '{half: 10.0, lo: 127, hi: 129, good: 1'b1}, nwin: 5, exp_lock: 1'b1};

    // Reset held with mon_clk running.
    repeat (10) @(negedge clk_in);
    chk("rst_locked", locked_out, 0, 0);
    chk("rst_fault", fault, 0, 0);
    chk("rst_valid", meas_valid, 0, 0);
    chk("rst_meas", int'(meas_count), 0, 0);
    resetn = 1'b1;
    repeat (10) @(negedge clk_in);

    // Constant-frequency scenarios: 44 MHz, edges 134, 124, 131, exact 50 MHz.
    foreach (tbl[i]) begin
      plan.delete();
      for (int k = 0; k < tbl[i].nwin; k++) plan.push_back(tbl[i].w);
      run_plan(1'b1);
      chk("tbl_final_lock", locked_out, int'(tbl[i].exp_lock), int'(tbl[i].exp_lock));
    end

    // Stop mon_clk while locked, then restart it; fault must stick.
    mon_run = 1'b0;
    plan.delete();
    plan.push_back('{half: 10.0, lo: 0, hi: 1, good: 1'b0});
    plan.push_back('{half: 10.0, lo: 0, hi: 0, good: 1'b0});
    run_plan(1'b0);
    mon_run = 1'b1;
    plan.delete();
    plan.push_back('{half: 10.0, lo: 127, hi: 129, good: 1'b1});
    run_plan(1'b0);
    @(negedge clk_in);
    chk("valid_pulse", meas_valid, 0, 0);
    enable = 1'b0;
    @(negedge clk_in);
    chk("dis_fault", fault, 0, 0);
    chk("dis_locked", locked_out, 0, 0);
    chk("dis_meas_hold", int'(meas_count), 127, 129);

    // Random per-window frequencies, mostly inside tolerance.
    plan.delete();
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 9) < 7) n = $urandom_range(EXPECT - TOL, EXPECT + TOL - 1);
      else if ($urandom_range(0, 1) == 1) n = $urandom_range(100, EXPECT - TOL - 2);
      else n = $urandom_range(EXPECT + TOL + 1, 160);
      plan.push_back(mk(n));
    end
    run_plan(1'b1);

    // Alternating good/bad windows never lock.
    plan.delete();
    for (int k = 0; k < 7; k++) plan.push_back(mk((k % 2 == 0) ? 128 : 110));
    run_plan(1'b1);

    // Reset pulse mid-window while locked, then relock.
    plan.delete();
    for (int k = 0; k < LOCK_CNT; k++) plan.push_back('{half: 10.0, lo: 127, hi: 129, good: 1'b1});
    run_plan(1'b1);
    repeat (400) @(negedge clk_in);
    #2 resetn = 1'b0;
    #1;
    chk("async_locked", locked_out, 0, 0);
    chk("async_fault", fault, 0, 0);
    chk("async_valid", meas_valid, 0, 0);
    chk("async_meas", int'(meas_count), 0, 0);
    repeat (3) @(negedge clk_in);
    resetn = 1'b1;
    cnt = 0;
    nvalid = 0;
    first_v = 0;
    while (!locked_out && cnt < (LOCK_CNT + 1) * WINDOW + 50) begin
      @(negedge clk_in);
      cnt++;
      if (meas_valid) begin
        nvalid++;
        if (nvalid == 1) first_v = cnt;
      end
    end
    chk("relock_first_valid", first_v, WINDOW + 1, WINDOW + 4);
    chk("relock_locked", locked_out, 1, 1);
    chk("relock_windows", nvalid, LOCK_CNT, LOCK_CNT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
